// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// One source granted per cycle; the winner's rd/data are registered.
module wb_port_arbiter #(
  parameter int N_SRC = 5,
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*5-1:0]    src_rd,
  input  logic [N_SRC*XLEN-1:0] src_data,
  output logic [N_SRC-1:0]      src_ready,
  input  logic                  wb_stall,
  input  logic                  flush,
  output logic [SEL_W-1:0]      mux_sel,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  logic [4:0]      rd_arr   [N_SRC];
  logic [XLEN-1:0] data_arr [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign rd_arr[i]   = src_rd[5*i +: 5];
    assign data_arr[i] = src_data[XLEN*i +: XLEN];
  end

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

  logic             gnt_ok;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   idx;

  // Search from ptr with explicit wrap, so N_SRC need not be a power of two.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N_SRC))
        idx = idx - (SEL_W+1)'(N_SRC);
      if (!gnt_ok && src_valid[idx[SEL_W-1:0]]) begin
        gnt_ok  = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
    if (reset || wb_stall || flush)
      gnt_ok = 1'b0;
  end

  always_comb begin
    src_ready = '0;
    if (gnt_ok)
      src_ready = N_SRC'(1) << gnt_idx;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    mux_sel_d  = mux_sel_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_ok) begin
      if (gnt_idx == SEL_W'(N_SRC-1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + 1'b1;
      rf_we_d    = |rd_arr[gnt_idx];
      mux_sel_d  = gnt_idx;
      rf_waddr_d = rd_arr[gnt_idx];
      rf_wdata_d = data_arr[gnt_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      mux_sel_q  <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      mux_sel_q  <= mux_sel_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then randomized
// traffic against a round-robin reference model.
module tb_wb_port_arbiter;

  localparam int N  = 5;
  localparam int XL = 32;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_valid;
  logic [N*5-1:0]  src_rd;
  logic [N*XL-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            wb_stall;
  logic            flush;
  logic [SW-1:0]   mux_sel;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XL-1:0]   rf_wdata;

  wb_port_arbiter #(.N_SRC(N), .XLEN(XL), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready), .wb_stall(wb_stall), .flush(flush),
    .mux_sel(mux_sel), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic          v_valid [N];
  logic [4:0]    v_rd    [N];
  logic [XL-1:0] v_data  [N];
  int            wt      [N];
  bit            chk_starve = 0;

  int            m_ptr;
  logic          e_we;
  logic [4:0]    e_waddr;
  logic [XL-1:0] e_wdata;
  int            e_sel;
  int            last_g;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (reset || wb_stall || flush) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      src_valid[i]       = v_valid[i];
      src_rd[5*i +: 5]   = v_rd[i];
      src_data[XL*i +: XL] = v_data[i];
    end
  endtask

  task automatic chk_out(string tag);
    chk({tag, ":we"}, 64'(rf_we), 64'(e_we));
    chk({tag, ":waddr"}, 64'(rf_waddr), 64'(e_waddr));
    chk({tag, ":wdata"}, 64'(rf_wdata), 64'(e_wdata));
    chk({tag, ":sel"}, 64'(mux_sel), 64'(e_sel));
    chk({tag, ":selrange"}, 64'(int'(mux_sel) < N), 64'd1);
  endtask

  task automatic model_reset();
    m_ptr = 0; e_we = 0; e_waddr = 0; e_wdata = 0; e_sel = 0;
  endtask

  task automatic step(string tag);
    int g;
    logic [N-1:0] er;
    apply();
    #1;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, ":ready"}, 64'(src_ready), 64'(er));
    if (chk_starve)
      for (int i = 0; i < N; i++)
        if (v_valid[i]) begin
          if (i == g) begin
            chk({tag, ":starve"}, 64'(wt[i] < N), 64'd1);
            wt[i] = 0;
          end else if (!wb_stall && !flush) wt[i]++;
        end
    if (g >= 0) begin
      e_we    = (v_rd[g] != 0);
      e_waddr = v_rd[g];
      e_wdata = v_data[g];
      e_sel   = g;
      m_ptr   = (g + 1) % N;
    end else e_we = 0;
    last_g = g;
    @(posedge clk);
    #1;
    chk_out(tag);
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      v_valid[i] = 0; v_rd[i] = 0; v_data[i] = 0; wt[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    wb_stall = 0; flush = 0; reset = 1;
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst");
    v_valid[2] = 1; v_rd[2] = 9; v_data[2] = 32'h1234_5678;
    apply();
    #1;
    chk("rst:ready", 64'(src_ready), 64'd0);
    reset = 0;
    step("pre");
    chk("pre:we", 64'(rf_we), 64'd1);
    // async reset mid-grant
    reset = 1;
    #1;
    model_reset();
    chk_out("arst");
    chk("arst:ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    reset = 0;

    // round robin from ptr=0
    for (int i = 0; i < N; i++) begin
      v_valid[i] = 1; v_rd[i] = 5'(i + 1); v_data[i] = $urandom;
    end
    for (int k = 0; k < 6; k++) begin
      step("rr");
      chk("rr:sel", 64'(mux_sel), 64'(k % N));
    end

    // single source
    clr();
    v_valid[2] = 1; v_rd[2] = 7; v_data[2] = 32'hDEAD_BEEF;
    apply();
    #1;
    chk("single:ready", 64'(src_ready), 64'b00100);
    step("single");
    chk("single:waddr", 64'(rf_waddr), 64'd7);
    chk("single:wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("single:sel", 64'(mux_sel), 64'd2);
    clr();
    v_valid[3] = 1; v_rd[3] = 3; v_data[3] = 32'h3333;
    step("toptr4");

    // wrap and skip from ptr=4
    clr();
    v_valid[0] = 1; v_rd[0] = 4; v_data[0] = 32'hA0;
    v_valid[1] = 1; v_rd[1] = 5; v_data[1] = 32'hA1;
    step("wrap0");
    chk("wrap0:sel", 64'(mux_sel), 64'd0);
    v_valid[0] = 0;
    step("wrap1");
    chk("wrap1:sel", 64'(mux_sel), 64'd1);

    // write to x0 then stall
    clr();
    v_valid[0] = 1; v_rd[0] = 0; v_data[0] = 32'hFFFF;
    step("x0");
    chk("x0:we", 64'(rf_we), 64'd0);
    chk("x0:sel", 64'(mux_sel), 64'd0);
    clr();
    v_valid[1] = 1; v_rd[1] = 17; v_data[1] = 32'h5151;
    wb_stall = 1;
    for (int k = 0; k < 3; k++) step("stall");
    wb_stall = 0;
    step("unstall");
    chk("unstall:sel", 64'(mux_sel), 64'd1);

    // flush, including flush over stall
    clr();
    v_valid[3] = 1; v_rd[3] = 12; v_data[3] = 32'hC3C3;
    flush = 1;
    step("flush");
    wb_stall = 1;
    step("flushstall");
    flush = 0; wb_stall = 0;
    step("postflush");
    chk("postflush:waddr", 64'(rf_waddr), 64'd12);

    // randomized traffic
    clr();
    chk_starve = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v_valid[i] && $urandom_range(1, 0) == 1) begin
          v_valid[i] = 1;
          v_rd[i] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
          v_data[i] = $urandom;
          wt[i] = 0;
        end
      wb_stall = ($urandom_range(7, 0) == 0);
      flush = ($urandom_range(7, 0) == 0);
      step("rnd");
      if (last_g >= 0) v_valid[last_g] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
